// File: rtl/dc_ipu_addr_gen.sv
// dc_ipu_addr_gen: line-based texture address generator for the IPU scaler.
// Divides tex/img into a fixed-point step, then streams LANES clamped coords per beat.
module dc_ipu_addr_gen #(
    parameter int IMG_SIZE_WIDTH  = 12,
    parameter int TEX_SIZE_WIDTH  = 12,
    parameter int TEX_FRACT_WIDTH = 12,
    parameter int LANES           = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clr,
    input  logic                                 start,
    output logic                                 start_ready,
    input  logic [IMG_SIZE_WIDTH-1:0]            img_size,
    input  logic [TEX_SIZE_WIDTH-1:0]            tex_size,
    input  logic                                 center,
    output logic                                 err,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*TEX_SIZE_WIDTH-1:0]      tex_addr,
    output logic [LANES*TEX_FRACT_WIDTH-1:0]     tex_addr_fract,
    output logic [LANES-1:0]                     lane_mask,
    output logic                                 last
);

    localparam int IW    = IMG_SIZE_WIDTH;
    localparam int TW    = TEX_SIZE_WIDTH;
    localparam int FW    = TEX_FRACT_WIDTH;
    localparam int SW    = TW + FW;
    localparam int LG    = (LANES == 4) ? 2 : (LANES == 2) ? 1 : 0;
    // Extra LG bits keep lanes past the line end from wrapping negative.
    localparam int ACC_W = SW + 2 + LG;
    localparam int CW    = $clog2(SW + 1);
    localparam int BW    = IW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_SETUP,
        S_RUN
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]  img_r;
    logic [TW-1:0]  tex_r;
    logic           center_r;
    logic [SW-1:0]  quo;
    logic [IW-1:0]  rem;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  base;
    logic [BW-1:0]  nb;

    logic accept, size_zero, xfer;
    logic div_step, setup_step;
    logic load_first, load_next, line_done;

    logic [IW:0]    rem_sh;
    logic           div_ge;
    logic [IW-1:0]  rem_nxt;

    logic signed [ACC_W-1:0] s_ext, ls, half, p0, maxp;
    logic signed [ACC_W-1:0] off     [LANES];
    logic signed [ACC_W-1:0] off_nxt [LANES];

    logic [LANES*TW-1:0] addr_nxt;
    logic [LANES*FW-1:0] fract_nxt;
    logic [LANES-1:0]    mask_nxt;
    logic                last_nxt;

    assign size_zero = (img_size == '0) | (tex_size == '0);
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept && !size_zero) state_nxt = S_DIV;
            S_DIV:   if (cnt == CW'(SW - 1)) state_nxt = S_SETUP;
            S_SETUP: if (cnt == CW'(LANES - 1)) state_nxt = S_RUN;
            S_RUN:   if (line_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clr) state_nxt = S_IDLE;
    end

    always_comb begin
        start_ready = (state == S_IDLE);
        accept      = start_ready & start & ~clr;
        div_step    = (state == S_DIV);
        setup_step  = (state == S_SETUP);
        load_first  = setup_step & (cnt == CW'(LANES - 1));
        load_next   = (state == S_RUN) & xfer & ~last;
        line_done   = (state == S_RUN) & xfer & last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (div_step | setup_step) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Restoring divider: quo doubles as dividend shifter and quotient.
    assign rem_sh  = {rem, quo[SW-1]};
    assign div_ge  = rem_sh[IW] | (rem_sh[IW-1:0] >= img_r);
    assign rem_nxt = div_ge ? (rem_sh[IW-1:0] - img_r) : rem_sh[IW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            img_r    <= '0;
            tex_r    <= '0;
            center_r <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            err      <= 1'b0;
        end else begin
            err <= accept & size_zero;
            if (accept) begin
                img_r    <= img_size;
                tex_r    <= tex_size;
                center_r <= center;
                quo      <= {tex_size, {FW{1'b0}}};
                rem      <= '0;
            end else if (div_step) begin
                quo <= {quo[SW-2:0], div_ge};
                rem <= rem_nxt;
            end
        end
    end

    assign s_ext = {{(ACC_W - SW){1'b0}}, quo};
    assign ls    = s_ext <<< LG;
    assign half  = ACC_W'(1) << (FW - 1);
    assign p0    = center_r ? ((s_ext >>> 1) - half) : '0;
    assign maxp  = {{(ACC_W - SW){1'b0}}, tex_r - TW'(1), {FW{1'b0}}};

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            off_nxt[k] = off[k];
        end
        if (setup_step) begin
            if (cnt == '0) off_nxt[0] = p0;
            for (int k = 1; k < LANES; k++) begin
                if (cnt == CW'(k)) off_nxt[k] = off[k-1] + s_ext;
            end
        end
        if (load_next) begin
            for (int k = 0; k < LANES; k++) begin
                off_nxt[k] = off[k] + ls;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LANES; k++) begin
                off[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                off[k] <= off_nxt[k];
            end
        end
    end

    assign nb = load_first ? '0 : (base + BW'(LANES));

    always_comb begin
        addr_nxt  = '0;
        fract_nxt = '0;
        mask_nxt  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (off_nxt[k] < 0) begin
                addr_nxt[k*TW +: TW]  = '0;
                fract_nxt[k*FW +: FW] = '0;
            end else if (off_nxt[k] > maxp) begin
                addr_nxt[k*TW +: TW]  = tex_r - TW'(1);
                fract_nxt[k*FW +: FW] = '0;
            end else begin
                addr_nxt[k*TW +: TW]  = off_nxt[k][SW-1:FW];
                fract_nxt[k*FW +: FW] = off_nxt[k][FW-1:0];
            end
            mask_nxt[k] = (nb + BW'(k)) < BW'(img_r);
        end
        last_nxt = (nb + BW'(LANES)) >= BW'(img_r);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            last           <= 1'b0;
            tex_addr       <= '0;
            tex_addr_fract <= '0;
            lane_mask      <= '0;
            base           <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
            last      <= 1'b0;
        end else if (load_first | load_next) begin
            out_valid      <= 1'b1;
            last           <= last_nxt;
            tex_addr       <= addr_nxt;
            tex_addr_fract <= fract_nxt;
            lane_mask      <= mask_nxt;
            base           <= nb;
        end else if (line_done) begin
            out_valid <= 1'b0;
            last      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dc_ipu_addr_gen.sv
// tb_dc_ipu_addr_gen: directed vectors for dc_ipu_addr_gen.
// Checks LANES=2 and LANES=4 instances against hand-computed coordinates.
module tb_dc_ipu_addr_gen;

    logic        clk = 1'b0;
    logic        reset, clr, start, start4, center, out_ready, out_ready4;
    logic [11:0] img_size, tex_size;

    logic        start_ready, err, out_valid, last;
    logic [23:0] tex_addr, tex_addr_fract;
    logic [1:0]  lane_mask;

    logic        start_ready4, err4, out_valid4, last4;
    logic [47:0] tex_addr4, tex_addr_fract4;
    logic [3:0]  lane_mask4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dc_ipu_addr_gen #(
        .IMG_SIZE_WIDTH(12), .TEX_SIZE_WIDTH(12),
        .TEX_FRACT_WIDTH(12), .LANES(2)
    ) u2 (
        .clk(clk), .reset(reset), .clr(clr), .start(start),
        .start_ready(start_ready), .img_size(img_size),
        .tex_size(tex_size), .center(center), .err(err),
        .out_valid(out_valid), .out_ready(out_ready),
        .tex_addr(tex_addr), .tex_addr_fract(tex_addr_fract),
        .lane_mask(lane_mask), .last(last)
    );

    dc_ipu_addr_gen #(
        .IMG_SIZE_WIDTH(12), .TEX_SIZE_WIDTH(12),
        .TEX_FRACT_WIDTH(12), .LANES(4)
    ) u4 (
        .clk(clk), .reset(reset), .clr(clr), .start(start4),
        .start_ready(start_ready4), .img_size(img_size),
        .tex_size(tex_size), .center(center), .err(err4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .tex_addr(tex_addr4), .tex_addr_fract(tex_addr_fract4),
        .lane_mask(lane_mask4), .last(last4)
    );

    typedef struct {
        bit newcmd;
        bit ctr;
        int img;
        int tex;
        int a0, f0, a1, f1;
        int mask;
        bit lst;
    } beat_t;

    beat_t tbl [10];

    function automatic beat_t mk(bit n, bit c, int i, int t, int a0, int f0,
                                 int a1, int f1, int m, bit l);
        beat_t r;
        r.newcmd = n; r.ctr = c; r.img = i; r.tex = t;
        r.a0 = a0; r.f0 = f0; r.a1 = a1; r.f1 = f1;
        r.mask = m; r.lst = l;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!out_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid got timeout want out_valid");
        end
    endtask

    task automatic issue(input bit c, input int img, input int tex);
        chk("ready_before_start", start_ready, 1);
        center   = c;
        img_size = 12'(img);
        tex_size = 12'(tex);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic count_valid(input int cyc, output int vc);
        vc = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (out_valid) vc++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ea, ef;
        int n, vc;

        tbl[0] = mk(1, 0, 4, 2, 0, 0,    0, 2048, 3, 0);
        tbl[1] = mk(0, 0, 4, 2, 1, 0,    1, 0,    3, 1);
        tbl[2] = mk(1, 1, 4, 2, 0, 0,    0, 1024, 3, 0);
        tbl[3] = mk(0, 1, 4, 2, 0, 3072, 1, 0,    3, 1);
        tbl[4] = mk(1, 0, 3, 3, 0, 0,    1, 0,    3, 0);
        tbl[5] = mk(0, 0, 3, 3, 2, 0,    2, 0,    1, 1);
        tbl[6] = mk(1, 0, 1, 1, 0, 0,    0, 0,    1, 1);
        tbl[7] = mk(1, 1, 5, 2, 0, 0,    0, 409,  3, 0);
        tbl[8] = mk(0, 1, 5, 2, 0, 2047, 0, 3685, 3, 0);
        tbl[9] = mk(0, 1, 5, 2, 1, 0,    1, 0,    1, 1);

        reset = 1'b1; clr = 1'b0; start = 1'b0; start4 = 1'b0;
        center = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
        img_size = '0; tex_size = '0;
        repeat (2) @(negedge clk);

        chk("rst_ready", start_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", tex_addr, 0);
        chk("rst_fract", tex_addr_fract, 0);
        chk("rst_mask_last", {lane_mask, last}, 0);
        chk("rst4_outs", {out_valid4, tex_addr4, lane_mask4, last4}, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].newcmd) issue(tbl[i].ctr, tbl[i].img, tbl[i].tex);
            wait_valid(60);
            ea = (64'(tbl[i].a1) << 12) | 64'(tbl[i].a0);
            ef = (64'(tbl[i].f1) << 12) | 64'(tbl[i].f0);
            chk($sformatf("t%0d_addr", i), tex_addr, ea);
            chk($sformatf("t%0d_fract", i), tex_addr_fract, ef);
            chk($sformatf("t%0d_mask_last", i), {lane_mask, last},
                {tbl[i].mask[1:0], tbl[i].lst});
            @(negedge clk);
        end
        chk("tbl_idle_after", out_valid, 0);

        // Latency: accept cycle is 0, first valid cycle must be 27.
        center = 1'b1; img_size = 12'd2; tex_size = 12'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("lat_cycles", n, 27);
        chk("lat_addr", tex_addr, (64'd2 << 12));
        chk("lat_fract", tex_addr_fract, (64'd2048 << 12) | 64'd2048);
        chk("lat_mask_last", {lane_mask, last}, 3'b111);
        @(negedge clk);

        // LANES=4 single-beat line with a masked lane.
        center = 1'b0; img_size = 12'd3; tex_size = 12'd2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("l4_valid", out_valid4, 1);
        chk("l4_addr", tex_addr4, (64'd1 << 36) | (64'd1 << 24));
        chk("l4_fract", tex_addr_fract4, 64'd2730 << 12);
        chk("l4_mask_last", {lane_mask4, last4}, 5'b01111);
        @(negedge clk);
        chk("l4_done", out_valid4, 0);

        // Backpressure on beats 1 and 2.
        issue(0, 8, 8);
        for (int b = 0; b < 4; b++) begin
            wait_valid(60);
            ea = (64'(2 * b + 1) << 12) | 64'(2 * b);
            chk($sformatf("bp%0d_addr", b), tex_addr, ea);
            chk($sformatf("bp%0d_fract", b), tex_addr_fract, 0);
            chk($sformatf("bp%0d_mask_last", b), {lane_mask, last},
                {2'b11, (b == 3)});
            if (b == 1 || b == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("bp_stall_valid", out_valid, 1);
                    chk("bp_stall_addr", tex_addr, ea);
                    chk("bp_stall_last", last, 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        count_valid(3, vc);
        chk("bp_no_extra", vc, 0);

        // clr during DIV.
        issue(0, 4, 2);
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_div_ready", start_ready, 1);
        count_valid(40, vc);
        chk("clr_div_nobeats", vc, 0);

        // start together with clr is not accepted.
        center = 1'b0; img_size = 12'd4; tex_size = 12'd2;
        start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        chk("clr_start_ignored", start_ready, 1);

        // clr on a stalled beat.
        out_ready = 1'b0;
        issue(0, 4, 2);
        wait_valid(60);
        chk("clrst_fract", tex_addr_fract, 64'd2048 << 12);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clrst_valid", out_valid, 0);
        chk("clrst_last_ready", {last, start_ready}, 2'b01);
        out_ready = 1'b1;

        // Zero-size commands.
        center = 1'b0; img_size = 12'd0; tex_size = 12'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_img0", err, 1);
        chk("err_img0_ready", start_ready, 1);
        @(negedge clk);
        chk("err_pulse_end", err, 0);
        img_size = 12'd4; tex_size = 12'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_tex0", err, 1);
        count_valid(40, vc);
        chk("err_nobeats", vc, 0);

        // reset mid-RUN on the last beat.
        issue(0, 8, 8);
        wait_valid(60);
        repeat (3) @(negedge clk);
        chk("rstrun_pre_last", last, 1);
        chk("rstrun_pre_addr", tex_addr, (64'd7 << 12) | 64'd6);
        #1 reset = 1'b1;
        #1;
        chk("rstrun_valid", out_valid, 0);
        chk("rstrun_addr", tex_addr, 0);
        chk("rstrun_fract_mask_last",
            {tex_addr_fract, lane_mask, last}, 0);
        chk("rstrun_ready", start_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        count_valid(3, vc);
        chk("rstrun_nobeats", vc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
